// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types for the memory request controller
package mem_ctrl_pkg;

    localparam int STATE_BITS = 2;

    typedef enum logic [STATE_BITS-1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        WRITE_WAIT = 2'd2,
        RELAY      = 2'd3
    } channel_state_t;

endpackage

// File: rtl/mem_ctrl_channel.sv
// rtl/mem_ctrl_channel.sv - one memory channel: request FSM, registered memory-side outputs
// and the response held for the owning consumer until it drops its valid.
module mem_ctrl_channel
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_BITS  = 8,
    parameter int DATA_BITS  = 8,
    parameter int OWNER_BITS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  grant,
    input  logic                  grant_read,
    input  logic [OWNER_BITS-1:0] grant_owner,
    input  logic [ADDR_BITS-1:0]  grant_read_address,
    input  logic [ADDR_BITS-1:0]  grant_write_address,
    input  logic [DATA_BITS-1:0]  grant_write_data,
    input  logic                  owner_read_valid,
    input  logic                  owner_write_valid,
    input  logic                  mem_read_ready,
    input  logic                  mem_write_ready,
    input  logic [DATA_BITS-1:0]  mem_read_data,
    output logic                  idle,
    output logic [OWNER_BITS-1:0] owner,
    output logic                  mem_read_valid,
    output logic [ADDR_BITS-1:0]  mem_read_address,
    output logic                  mem_write_valid,
    output logic [ADDR_BITS-1:0]  mem_write_address,
    output logic [DATA_BITS-1:0]  mem_write_data,
    output logic                  resp_read_ready,
    output logic                  resp_write_ready,
    output logic [DATA_BITS-1:0]  resp_read_data,
    output logic                  release_claim
);

    channel_state_t        state_q, state_d;
    logic [OWNER_BITS-1:0] owner_q, owner_d;
    logic                  mem_read_valid_q, mem_read_valid_d;
    logic [ADDR_BITS-1:0]  mem_read_address_q, mem_read_address_d;
    logic                  mem_write_valid_q, mem_write_valid_d;
    logic [ADDR_BITS-1:0]  mem_write_address_q, mem_write_address_d;
    logic [DATA_BITS-1:0]  mem_write_data_q, mem_write_data_d;
    logic                  resp_read_ready_q, resp_read_ready_d;
    logic                  resp_write_ready_q, resp_write_ready_d;
    logic [DATA_BITS-1:0]  resp_read_data_q, resp_read_data_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q             <= IDLE;
            owner_q             <= '0;
            mem_read_valid_q    <= 1'b0;
            mem_read_address_q  <= '0;
            mem_write_valid_q   <= 1'b0;
            mem_write_address_q <= '0;
            mem_write_data_q    <= '0;
            resp_read_ready_q   <= 1'b0;
            resp_write_ready_q  <= 1'b0;
            resp_read_data_q    <= '0;
        end else begin
            state_q             <= state_d;
            owner_q             <= owner_d;
            mem_read_valid_q    <= mem_read_valid_d;
            mem_read_address_q  <= mem_read_address_d;
            mem_write_valid_q   <= mem_write_valid_d;
            mem_write_address_q <= mem_write_address_d;
            mem_write_data_q    <= mem_write_data_d;
            resp_read_ready_q   <= resp_read_ready_d;
            resp_write_ready_q  <= resp_write_ready_d;
            resp_read_data_q    <= resp_read_data_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        mem_read_valid_d    = mem_read_valid_q;
        mem_read_address_d  = mem_read_address_q;
        mem_write_valid_d   = mem_write_valid_q;
        mem_write_address_d = mem_write_address_q;
        mem_write_data_d    = mem_write_data_q;
        resp_read_ready_d   = resp_read_ready_q;
        resp_write_ready_d  = resp_write_ready_q;
        resp_read_data_d    = resp_read_data_q;
        release_claim       = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    owner_d = grant_owner;
                    if (grant_read) begin
                        mem_read_valid_d   = 1'b1;
                        mem_read_address_d = grant_read_address;
                        state_d            = READ_WAIT;
                    end else begin
                        mem_write_valid_d   = 1'b1;
                        mem_write_address_d = grant_write_address;
                        mem_write_data_d    = grant_write_data;
                        state_d             = WRITE_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (mem_read_ready) begin
                    mem_read_valid_d  = 1'b0;
                    resp_read_data_d  = mem_read_data;
                    resp_read_ready_d = 1'b1;
                    state_d           = RELAY;
                end
            end
            WRITE_WAIT: begin
                if (mem_write_ready) begin
                    mem_write_valid_d  = 1'b0;
                    resp_write_ready_d = 1'b1;
                    state_d            = RELAY;
                end
            end
            RELAY: begin
                // Only the valid matching the completed operation ends the relay.
                if ((resp_read_ready_q && !owner_read_valid) ||
                    (resp_write_ready_q && !owner_write_valid)) begin
                    resp_read_ready_d  = 1'b0;
                    resp_write_ready_d = 1'b0;
                    release_claim      = 1'b1;
                    state_d            = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign idle              = (state_q == IDLE);
    assign owner             = owner_q;
    assign mem_read_valid    = mem_read_valid_q;
    assign mem_read_address  = mem_read_address_q;
    assign mem_write_valid   = mem_write_valid_q;
    assign mem_write_address = mem_write_address_q;
    assign mem_write_data    = mem_write_data_q;
    assign resp_read_ready   = resp_read_ready_q;
    assign resp_write_ready  = resp_write_ready_q;
    assign resp_read_data    = resp_read_data_q;

endmodule

// File: rtl/mem_request_controller.sv
// rtl/mem_request_controller.sv - grants free memory channels to LSU requests and relays results.
// MEM_CTRL_ROUND_ROBIN_EN selects a rotating consumer priority instead of lowest-index-first.
module mem_request_controller
    import mem_ctrl_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_write_data,
    input  logic [NUM_CHANNELS-1:0]            mem_write_ready
);

    localparam int OWNER_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    logic [NUM_CONSUMERS-1:0] claim_q, claim_d;
    logic [NUM_CHANNELS-1:0]  ch_idle, ch_grant, ch_grant_read, ch_release;
    logic [NUM_CHANNELS-1:0]  ch_resp_read_ready, ch_resp_write_ready;
    logic [OWNER_BITS-1:0]    ch_grant_owner [NUM_CHANNELS];
    logic [OWNER_BITS-1:0]    ch_owner [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     ch_resp_read_data [NUM_CHANNELS];
`ifdef MEM_CTRL_ROUND_ROBIN_EN
    logic [OWNER_BITS-1:0]    rr_ptr_q, rr_ptr_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            claim_q  <= '0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
            rr_ptr_q <= '0;
`endif
        end else begin
            claim_q  <= claim_d;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
            rr_ptr_q <= rr_ptr_d;
`endif
        end
    end

    // Channels are visited in ascending order; a consumer taken by a lower channel is skipped.
    // A channel still seeing a trailing memory ready from its last request is not eligible.
    always_comb begin
        logic [NUM_CONSUMERS-1:0] taken;
        logic [NUM_CONSUMERS-1:0] released;
        int start;
        int idx;
        taken    = claim_q;
        released = '0;
        start    = 0;
        idx      = 0;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
        start    = int'(rr_ptr_q);
        rr_ptr_d = rr_ptr_q;
`endif
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ch_grant[c]       = 1'b0;
            ch_grant_read[c]  = 1'b0;
            ch_grant_owner[c] = '0;
            if (ch_idle[c] && !mem_read_ready[c] && !mem_write_ready[c]) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    idx = (start + k) % NUM_CONSUMERS;
                    if (!ch_grant[c] && !taken[idx] &&
                        (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                        ch_grant[c]       = 1'b1;
                        ch_grant_read[c]  = consumer_read_valid[idx];
                        ch_grant_owner[c] = OWNER_BITS'(idx);
                        taken[idx]        = 1'b1;
`ifdef MEM_CTRL_ROUND_ROBIN_EN
                        rr_ptr_d          = OWNER_BITS'((idx + 1) % NUM_CONSUMERS);
`endif
                    end
                end
            end
            if (ch_release[c]) begin
                released[ch_owner[c]] = 1'b1;
            end
        end
        claim_d = (claim_q & ~released) | (taken & ~claim_q);
    end

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        mem_ctrl_channel #(
            .ADDR_BITS  (ADDR_BITS),
            .DATA_BITS  (DATA_BITS),
            .OWNER_BITS (OWNER_BITS)
        ) u_channel (
            .clk                 (clk),
            .reset               (reset),
            .grant               (ch_grant[c]),
            .grant_read          (ch_grant_read[c]),
            .grant_owner         (ch_grant_owner[c]),
            .grant_read_address  (consumer_read_address[ch_grant_owner[c]*ADDR_BITS +: ADDR_BITS]),
            .grant_write_address (consumer_write_address[ch_grant_owner[c]*ADDR_BITS +: ADDR_BITS]),
            .grant_write_data    (consumer_write_data[ch_grant_owner[c]*DATA_BITS +: DATA_BITS]),
            .owner_read_valid    (consumer_read_valid[ch_owner[c]]),
            .owner_write_valid   (consumer_write_valid[ch_owner[c]]),
            .mem_read_ready      (mem_read_ready[c]),
            .mem_write_ready     (mem_write_ready[c]),
            .mem_read_data       (mem_read_data[c*DATA_BITS +: DATA_BITS]),
            .idle                (ch_idle[c]),
            .owner               (ch_owner[c]),
            .mem_read_valid      (mem_read_valid[c]),
            .mem_read_address    (mem_read_address[c*ADDR_BITS +: ADDR_BITS]),
            .mem_write_valid     (mem_write_valid[c]),
            .mem_write_address   (mem_write_address[c*ADDR_BITS +: ADDR_BITS]),
            .mem_write_data      (mem_write_data[c*DATA_BITS +: DATA_BITS]),
            .resp_read_ready     (ch_resp_read_ready[c]),
            .resp_write_ready    (ch_resp_write_ready[c]),
            .resp_read_data      (ch_resp_read_data[c]),
            .release_claim       (ch_release[c])
        );
    end

    always_comb begin
        consumer_read_ready  = '0;
        consumer_write_ready = '0;
        consumer_read_data   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (ch_resp_read_ready[c]) begin
                consumer_read_ready[ch_owner[c]] = 1'b1;
                consumer_read_data[ch_owner[c]*DATA_BITS +: DATA_BITS] = ch_resp_read_data[c];
            end
            if (ch_resp_write_ready[c]) begin
                consumer_write_ready[ch_owner[c]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_request_controller.sv
// tb/tb_mem_request_controller.sv - directed and randomized checks of mem_request_controller
// against a registered memory model and a scoreboard of expected memory contents.
module tb_mem_request_controller;

    localparam int NC  = 4;
    localparam int NCH = 2;
    localparam int AW  = 8;
    localparam int DW  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NC-1:0]     consumer_read_valid;
    logic [NC*AW-1:0]  consumer_read_address;
    logic [NC-1:0]     consumer_read_ready;
    logic [NC*DW-1:0]  consumer_read_data;
    logic [NC-1:0]     consumer_write_valid;
    logic [NC*AW-1:0]  consumer_write_address;
    logic [NC*DW-1:0]  consumer_write_data;
    logic [NC-1:0]     consumer_write_ready;
    logic [NCH-1:0]    mem_read_valid;
    logic [NCH*AW-1:0] mem_read_address;
    logic [NCH-1:0]    mem_read_ready;
    logic [NCH*DW-1:0] mem_read_data;
    logic [NCH-1:0]    mem_write_valid;
    logic [NCH*AW-1:0] mem_write_address;
    logic [NCH*DW-1:0] mem_write_data;
    logic [NCH-1:0]    mem_write_ready;

    mem_request_controller #(
        .NUM_CONSUMERS (NC),
        .NUM_CHANNELS  (NCH),
        .ADDR_BITS     (AW),
        .DATA_BITS     (DW)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (consumer_read_valid),
        .consumer_read_address  (consumer_read_address),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (consumer_write_valid),
        .consumer_write_address (consumer_write_address),
        .consumer_write_data    (consumer_write_data),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    always #5 clk = ~clk;

    // One-cycle registered memory: ready echoes valid one cycle later (including a trailing cycle).
    logic [DW-1:0] mem_arr [256];
    always @(posedge clk) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem_arr[a] <= 8'(a) ^ 8'hA0;
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            mem_read_data   <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                mem_read_ready[c]  <= mem_read_valid[c];
                mem_write_ready[c] <= mem_write_valid[c];
                mem_read_data[c*DW +: DW] <= mem_arr[mem_read_address[c*AW +: AW]];
                if (mem_write_valid[c] && !mem_write_ready[c])
                    mem_arr[mem_write_address[c*AW +: AW]] <= mem_write_data[c*DW +: DW];
            end
        end
    end

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [256];
    logic [NC-1:0] pend_rd, pend_wr, just_done;
    logic [AW-1:0] rd_addr [NC];
    logic [AW-1:0] wr_addr [NC];
    logic [DW-1:0] wr_data [NC];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_read(input int i, input logic [AW-1:0] a);
        consumer_read_address[i*AW +: AW] = a;
        consumer_read_valid[i] = 1'b1;
        pend_rd[i] = 1'b1;
        rd_addr[i] = a;
    endtask

    task automatic issue_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        consumer_write_address[i*AW +: AW] = a;
        consumer_write_data[i*DW +: DW] = d;
        consumer_write_valid[i] = 1'b1;
        pend_wr[i] = 1'b1;
        wr_addr[i] = a;
        wr_data[i] = d;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        consumer_read_valid = '0;
        consumer_write_valid = '0;
        pend_rd = '0;
        pend_wr = '0;
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'hA0;
        repeat (cycles) tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_consumer"}, 64'({consumer_read_ready, consumer_read_data, consumer_write_ready}), 64'd0);
        check({tag, "_mem"}, 64'({mem_read_valid, mem_read_address, mem_write_valid, mem_write_address}), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_write_data), 64'd0);
    endtask

    // One cycle of the consumer-side model: accept responses, check them, drop the matching valid.
    task automatic step();
        tick();
        just_done = '0;
        check("spurious_ready", 64'({consumer_read_ready & ~pend_rd, consumer_write_ready & ~pend_wr}), 64'd0);
        for (int i = 0; i < NC; i++) begin
            if (pend_rd[i] && consumer_read_ready[i]) begin
                check($sformatf("rd_data_c%0d_a%0h", i, rd_addr[i]),
                      64'(consumer_read_data[i*DW +: DW]), 64'(ref_mem[rd_addr[i]]));
                consumer_read_valid[i] = 1'b0;
                pend_rd[i] = 1'b0;
                just_done[i] = 1'b1;
            end else if (pend_wr[i] && consumer_write_ready[i]) begin
                ref_mem[wr_addr[i]] = wr_data[i];
                consumer_write_valid[i] = 1'b0;
                pend_wr[i] = 1'b0;
                just_done[i] = 1'b1;
            end
        end
    endtask

    task automatic service(input int budget);
        int n = 0;
        while ((pend_rd != '0 || pend_wr != '0) && n < budget) begin
            step();
            n++;
        end
        check("drain_complete", 64'({pend_rd, pend_wr}), 64'd0);
        repeat (4) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        consumer_read_address  = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        apply_reset(3);
        check_outputs_zero("reset_state");
        reset = 1'b0;
        tick();

        // Single read: consumer 0 reads 0x05, memory holds 0xA5 there.
        issue_read(0, 8'h05);
        tick();
        check("rd1_mem_valid", 64'(mem_read_valid), 64'b01);
        check("rd1_mem_addr", 64'(mem_read_address[7:0]), 64'h05);
        tick();
        check("rd1_no_early_ready", 64'(consumer_read_ready), 64'd0);
        tick();
        check("rd1_ready_cycle3", 64'(consumer_read_ready), 64'b0001);
        check("rd1_data_cycle3", 64'(consumer_read_data[7:0]), 64'hA5);
        tick();
        check("rd1_ready_held", 64'(consumer_read_ready), 64'b0001);
        check("rd1_data_held", 64'(consumer_read_data[7:0]), 64'hA5);
        service(20);

        // Single write: consumer 2 writes 0x3C to 0x10 on channel 0.
        issue_write(2, 8'h10, 8'h3C);
        tick();
        check("wr1_mem_valid", 64'(mem_write_valid), 64'b01);
        check("wr1_mem_addr", 64'(mem_write_address[7:0]), 64'h10);
        check("wr1_mem_data", 64'(mem_write_data[7:0]), 64'h3C);
        check("wr1_no_read", 64'(mem_read_valid), 64'd0);
        tick();
        check("wr1_no_early_ready", 64'(consumer_write_ready), 64'd0);
        tick();
        check("wr1_ready_cycle3", 64'(consumer_write_ready), 64'b0100);
        service(20);
        check("wr1_mem_contents", 64'(mem_arr[8'h10]), 64'h3C);

        // Contention: four readers, two channels.
        for (int i = 0; i < NC; i++) issue_read(i, 8'(i + 1));
        tick();
        check("cont_mem_valid", 64'(mem_read_valid), 64'b11);
        check("cont_mem_addr", 64'(mem_read_address), 64'h0201);
        tick();
        tick();
        check("cont_first_pair", 64'(consumer_read_ready), 64'b0011);
        service(60);

        // Read and write from the same consumer: read goes first.
        issue_read(1, 8'h22);
        issue_write(1, 8'h91, 8'h77);
        tick();
        check("rw_read_first", 64'(mem_read_valid), 64'b01);
        check("rw_no_write_yet", 64'(mem_write_valid), 64'd0);
        check("rw_read_addr", 64'(mem_read_address[7:0]), 64'h22);
        service(60);
        check("rw_mem_contents", 64'(mem_arr[8'h91]), 64'h77);

        // Reset while the read is in flight.
        issue_read(0, 8'h33);
        tick();
        check("rst_mem_valid", 64'(mem_read_valid), 64'b01);
        apply_reset(1);
        check_outputs_zero("rst_mid");
        reset = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("rst_no_stale_ready", 64'({consumer_read_ready, consumer_write_ready}), 64'd0);
        end
        issue_read(0, 8'h44);
        service(20);

`ifdef MEM_CTRL_ROUND_ROBIN_EN
        begin
            int n = 0;
            issue_read(0, 8'h01);
            issue_read(3, 8'h03);
            while (pend_rd[3] && n < 20) begin
                step();
                if (!pend_rd[0] && !just_done[0]) issue_read(0, 8'h01);
                n++;
            end
            check("rr_consumer3_served", 64'(pend_rd[3]), 64'd0);
            service(40);
        end
`endif

        // Randomized traffic; consumers write only to private regions so order is unambiguous.
        for (int cyc = 0; cyc < 400; cyc++) begin
            step();
            for (int i = 0; i < NC; i++) begin
                if (!pend_rd[i] && !pend_wr[i] && !just_done[i] && $urandom_range(2) == 0) begin
                    case ($urandom_range(2))
                        0: issue_read(i, 8'($urandom_range(127)));
                        1: issue_write(i, 8'h80 | 8'(i << 5) | 8'($urandom_range(31)), 8'($urandom));
                        default: begin
                            issue_read(i, 8'($urandom_range(127)));
                            issue_write(i, 8'h80 | 8'(i << 5) | 8'($urandom_range(31)), 8'($urandom));
                        end
                    endcase
                end
            end
        end
        service(2000);
        for (int a = 128; a < 256; a++)
            check($sformatf("rand_mem_%0h", a), 64'(mem_arr[a]), 64'(ref_mem[a]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
